memory_line_fill_256bit: RTL

- Write-port driver for the 16-entry x 256-bit line memory: builds complete lines from a 32-bit memory bus (line fill), and merges single 32-bit stores into resident lines.
- Sits directly upstream of the line memory. Drives its iWR_ENA/iWR_ADDR/iWR_DATA/iBYTE_ENA.
- Read path of the line memory is untouched.

---
 rtl/memory_line_fill_256bit_pkg.sv | 16 +
 rtl/memory_line_fill_byteena_gen.sv | 27 ++
 rtl/memory_line_fill_256bit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/memory_line_fill_256bit_pkg.sv
// rtl/memory_line_fill_256bit_pkg.sv - shared types and constants for the line fill driver
// Purpose : FSM state encoding and line geometry shared by the line fill driver files.
// Ports   : none (package).
package memory_line_fill_256bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int L_LINE_BEATS = 8;
  localparam int L_LINE_BYTES = 32;
  localparam int L_WORD_BYTES = 4;

endpackage

// File: rtl/memory_line_fill_byteena_gen.sv
// rtl/memory_line_fill_byteena_gen.sv - store byte enable and data replication
// Purpose : turns a word index and 4-bit byte mask into a 32-bit line byte enable,
//           and replicates the 32-bit store data across the whole 256-bit line.
// Ports   : word     in  3    word within line
//           mask     in  4    byte mask within word
//           data     in  32   store data
//           byte_ena out 32   line byte enables
//           data_rep out 256  data replicated 8 times
module memory_line_fill_byteena_gen
  import memory_line_fill_256bit_pkg::*;
(
  input  logic [2:0]   word,
  input  logic [3:0]   mask,
  input  logic [31:0]  data,
  output logic [31:0]  byte_ena,
  output logic [255:0] data_rep
);

  logic [4:0] shift;

  // Byte offset of the selected word within the line (word * 4 bytes).
  assign shift    = 5'(word) * 5'(L_WORD_BYTES);
  assign byte_ena = {28'd0, mask} << shift;
  // Every word lane carries the store data; the byte enable picks the lane.
  assign data_rep = {L_LINE_BEATS{data}};

endmodule

// File: rtl/memory_line_fill_256bit.sv
// rtl/memory_line_fill_256bit.sv - write-port driver for the 16 x 256-bit line memory
// Purpose : fills whole lines from a 32-bit read bus and merges single 32-bit stores.
// Ports   : iCLOCK, iRESET_SYNC (sync, active-high)
//           iFILL_REQ/iFILL_LINE/iFILL_ADDR, oFILL_BUSY, oFILL_DONE   fill request side
//           iSTORE_REQ/iSTORE_LINE/iSTORE_WORD/iSTORE_MASK/iSTORE_DATA, oSTORE_BUSY
//           oMEM_REQ/oMEM_ADDR, iMEM_LOCK, iMEM_VALID/iMEM_DATA        read bus
//           oWR_ENA/oWR_ADDR/oWR_DATA/oBYTE_ENA                         line memory write port
module memory_line_fill_256bit
  import memory_line_fill_256bit_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = 8
) (
  input  logic         iCLOCK,
  input  logic         iRESET_SYNC,
  input  logic         iFILL_REQ,
  input  logic [3:0]   iFILL_LINE,
  input  logic [31:0]  iFILL_ADDR,
  output logic         oFILL_BUSY,
  output logic         oFILL_DONE,
  input  logic         iSTORE_REQ,
  input  logic [3:0]   iSTORE_LINE,
  input  logic [2:0]   iSTORE_WORD,
  input  logic [3:0]   iSTORE_MASK,
  input  logic [31:0]  iSTORE_DATA,
  output logic         oSTORE_BUSY,
  output logic         oMEM_REQ,
  output logic [31:0]  oMEM_ADDR,
  input  logic         iMEM_LOCK,
  input  logic         iMEM_VALID,
  input  logic [31:0]  iMEM_DATA,
  output logic         oWR_ENA,
  output logic [3:0]   oWR_ADDR,
  output logic [255:0] oWR_DATA,
  output logic [31:0]  oBYTE_ENA
);

  localparam logic [3:0] L_BEATS   = 4'(L_LINE_BEATS);
  localparam logic [3:0] L_MAX_OUT = 4'(P_MAX_OUTSTANDING);

  state_t         state;
  state_t         state_next;
  logic [3:0]     issue_cnt;
  logic [3:0]     recv_cnt;
  logic [255:0]   line_buf;
  logic [3:0]     fill_line;
  logic [26:0]    fill_base;

  logic           st_wr_ena;
  logic [3:0]     st_wr_addr;
  logic [255:0]   st_wr_data;
  logic [31:0]    st_byte_ena;

  logic           fill_acc;
  logic           store_acc;
  logic           mem_req;
  logic           beat_issue;
  logic           beat_recv;
  logic [31:0]    gen_byte_ena;
  logic [255:0]   gen_data;
  logic           addr_lsb_unused;

  // Line base is 32-byte aligned; the low address bits carry no information.
  assign addr_lsb_unused = ^iFILL_ADDR[4:0];

  // Fill takes priority: a store is only taken when no fill is requested.
  assign fill_acc  = (state == ST_IDLE) && iFILL_REQ;
  assign store_acc = (state == ST_IDLE) && !iFILL_REQ && iSTORE_REQ;

  // Request while beats remain and the outstanding window has room.
  assign mem_req    = (state == ST_FETCH) && (issue_cnt < L_BEATS) &&
                      ((issue_cnt - recv_cnt) < L_MAX_OUT);
  assign beat_issue = mem_req && !iMEM_LOCK;
  assign beat_recv  = (state == ST_FETCH) && iMEM_VALID && (recv_cnt < L_BEATS);

  memory_line_fill_byteena_gen u_byteena_gen (
    .word     (iSTORE_WORD),
    .mask     (iSTORE_MASK),
    .data     (iSTORE_DATA),
    .byte_ena (gen_byte_ena),
    .data_rep (gen_data)
  );

  // State register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (fill_acc) state_next = ST_FETCH;
      ST_FETCH: if (beat_recv && (recv_cnt == L_BEATS - 4'd1)) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counters, line buffer and the registered store write.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      line_buf    <= '0;
      fill_line   <= '0;
      fill_base   <= '0;
      st_wr_ena   <= 1'b0;
      st_wr_addr  <= '0;
      st_wr_data  <= '0;
      st_byte_ena <= '0;
    end else begin
      st_wr_ena <= store_acc;
      if (store_acc) begin
        st_wr_addr  <= iSTORE_LINE;
        st_wr_data  <= gen_data;
        st_byte_ena <= gen_byte_ena;
      end
      if (fill_acc) begin
        fill_line <= iFILL_LINE;
        fill_base <= iFILL_ADDR[31:5];
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (beat_issue) issue_cnt <= issue_cnt + 4'd1;
        if (beat_recv) begin
          // Beats return in order, so the receive count is the slot index.
          line_buf[{recv_cnt[2:0], 5'b00000} +: 32] <= iMEM_DATA;
          recv_cnt <= recv_cnt + 4'd1;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    oFILL_BUSY  = (state != ST_IDLE);
    oSTORE_BUSY = (state != ST_IDLE) || iFILL_REQ;
    oMEM_REQ    = mem_req;
    oMEM_ADDR   = '0;
    oFILL_DONE  = 1'b0;
    oWR_ENA     = 1'b0;
    oWR_ADDR    = '0;
    oWR_DATA    = '0;
    oBYTE_ENA   = '0;
    if (state == ST_FETCH) begin
      oMEM_ADDR = {fill_base, issue_cnt[2:0], 2'b00};
    end
    if (state == ST_WRITE) begin
      oWR_ENA    = 1'b1;
      oWR_ADDR   = fill_line;
      oWR_DATA   = line_buf;
      oBYTE_ENA  = {L_LINE_BYTES{1'b1}};
      oFILL_DONE = 1'b1;
    end else if (st_wr_ena) begin
      oWR_ENA   = 1'b1;
      oWR_ADDR  = st_wr_addr;
      oWR_DATA  = st_wr_data;
      oBYTE_ENA = st_byte_ena;
    end
  end

endmodule
